store_serializer: RTL
=====================

# store_serializer

Narrows CPU store requests onto an 8-bit memory write bus: it accepts one 32-bit store (byte, half or word) per handshake and emits 1, 2 or 4 byte beats, little-endian, each acknowledged by memory. It sits between the MEM stage's store path and a byte-wide data memory. This is the write-side counterpart of the immediate/load widening logic: data leaves the 32-bit datapath and is narrowed here. Misaligned requests are rejected with an error response.

## Interface
- Parameters: none. Address and data widths are fixed at 32 bits; the bus data width is fixed at 8 bits.
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- st_valid  in  1  store request present
- st_ready  out  1  block idle and can accept; reset 1
- st_addr  in  32  byte address of the store
- st_data  in  32  register data; low-order bytes are used for sb/sh
- st_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- mem_we  out  1  write beat valid; reset 0
- mem_addr  out  32  beat byte address; reset 0
- mem_wdata  out  8  beat data; reset 0
- mem_ack  in  1  beat accepted this cycle; meaningful only while mem_we=1
- done  out  1  one-cycle completion pulse; reset 0
- err  out  1  qualifies done: request rejected, nothing written; reset 0

## Operation
- States: IDLE, BEAT, RESP. Reset enters IDLE.
- **Accept.** A request is accepted when st_valid&&st_ready at the rising edge. At accept, the block latches addr, data and size, and clears beat counter cnt.
- **Beat count.** N = 1, 2 or 4 for size 00, 01 or 10.
- **Error check.** The request is an error if:
  - size is 11, or
  - size is 01 and addr[0]≠0, or
  - size is 10 and addr[1:0]≠0.
- **IDLE.**
  - On an accepted valid request: go to BEAT.
  - On an accepted error request: go to RESP with err latched at 1.
  - st_ready=1 only in IDLE.
- **BEAT.**
  - mem_we=1.
  - mem_addr = base+cnt; the sum is 32-bit and wraps modulo 2^32.
  - mem_wdata = data[8*cnt+7 : 8*cnt].
  - Outputs hold stable until mem_ack.
  - On mem_ack with cnt<N-1: cnt increments and the block stays in BEAT.
  - On mem_ack with cnt==N-1: go to RESP.
- **RESP.**
  - done=1 for exactly one cycle; err is valid with it.
  - Then return to IDLE, where done=0 and err=0.
- mem_ack is ignored outside BEAT.
- st_data bytes above size are never written.
- **Reset mid-operation.** Any in-flight store is dropped and no done is emitted. All outputs take their reset values at that edge.

## Timing
- Accept is at edge 0.
- The first beat is driven in cycle 1, so there is 1 cycle of latency to the first mem_we.
- With mem_ack held at 1:
  - sb: beat in cycle 1, done in cycle 2.
  - sh: beats in cycles 1–2, done in cycle 3.
  - sw: beats in cycles 1–4, done in cycle 5.
- Each mem_ack=0 cycle inserts one stall cycle with the beat held unchanged.
- Error path: accept at edge 0, done=err=1 in cycle 1, mem_we never asserts.
- Back-to-back stores: st_ready rises the cycle after done. Minimum issue interval is N+2 cycles.

## Configuration
- Macro: `STORE_SERIALIZER_ALIGN_CHECK_EN`.
- **Defined:** misalignment checks apply as described in Operation.
- **Undefined:**
  - Only size 11 is an error.
  - Misaligned half and word stores are written as N sequential bytes from st_addr, including across word boundaries.

## Structure
- Shared package store_serializer_pkg holds:
  - size codes SIZE_B, SIZE_H, SIZE_W, SIZE_RSV;
  - the state enum (S_IDLE, S_BEAT, S_RESP);
  - the function beats_for_size.
- One sub-module, store_byte_sel: combinational lane mux that selects a byte of the 32-bit word by 2-bit index.
- The FSM, counter and latches live in the top module.

## Test plan
- sb: addr=0x1003, data=0xAABBCCDD, ack always 1 -> one beat (0x1003, 0xDD), done at cycle 2, err=0.
- sw: addr=0x2000, data=0x11223344, ack low in cycle 2 -> beats 0x44, 0x33 (held one extra cycle), 0x22, 0x11 at 0x2000–0x2003; done at cycle 6.
- sh misaligned: addr=0x3001 -> done=err=1 in cycle 1, no mem_we; without the macro, beats 0x3001 and 0x3002 are written instead.
- size=11 -> err response; wrap case: sw at 0xFFFFFFFC with the macro undefined writes addresses FC–FF only.
- reset asserted during beat 2 of sw -> next cycle mem_we=0, st_ready=1, no done; a following sb completes normally.

Source files
------------

// File: rtl/store_serializer_pkg.sv
// Shared definitions for the store serializer: size codes, FSM states and
// the beat-count helper.
package store_serializer_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT,
        S_RESP
    } state_t;

    // Number of byte beats a store of the given size produces.
    function automatic logic [2:0] beats_for_size(input logic [1:0] size);
        case (size)
            SIZE_B:  beats_for_size = 3'd1;
            SIZE_H:  beats_for_size = 3'd2;
            SIZE_W:  beats_for_size = 3'd4;
            default: beats_for_size = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/store_byte_sel.sv
// Combinational byte-lane mux: picks byte idx (little-endian) out of a
// 32-bit word.
module store_byte_sel (
    input  logic [31:0] word,
    input  logic [1:0]  idx,
    output logic [7:0]  sel
);

    always_comb begin
        case (idx)
            2'd0:    sel = word[7:0];
            2'd1:    sel = word[15:8];
            2'd2:    sel = word[23:16];
            default: sel = word[31:24];
        endcase
    end

endmodule

// File: rtl/store_serializer.sv
// Narrows one 32-bit store onto a byte-wide write bus, one acked beat per byte.
// Define STORE_SERIALIZER_ALIGN_CHECK_EN to reject misaligned half/word stores.
module store_serializer
    import store_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        err
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [1:0]  cnt_q;
    logic        err_q;
    logic        req_err;
    logic        last_beat;
    logic [7:0]  lane_byte;

    always_comb begin
`ifdef STORE_SERIALIZER_ALIGN_CHECK_EN
        req_err = (st_size == SIZE_RSV)
               || (st_size == SIZE_H && st_addr[0])
               || (st_size == SIZE_W && st_addr[1:0] != 2'b00);
`else
        req_err = (st_size == SIZE_RSV);
`endif
    end

    assign last_beat = ({1'b0, cnt_q} == beats_for_size(size_q) - 3'd1);

    store_byte_sel u_byte_sel (
        .word (data_q),
        .idx  (cnt_q),
        .sel  (lane_byte)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SIZE_B;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (st_valid) begin
                        addr_q <= st_addr;
                        data_q <= st_data;
                        size_q <= st_size;
                        cnt_q  <= '0;
                        err_q  <= req_err;
                    end
                end
                S_BEAT: begin
                    if (mem_ack && !last_beat)
                        cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_d   = state_q;
        st_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                st_ready = 1'b1;
                if (st_valid)
                    state_d = req_err ? S_RESP : S_BEAT;
            end
            S_BEAT: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q + {30'd0, cnt_q};
                mem_wdata = lane_byte;
                if (mem_ack && last_beat)
                    state_d = S_RESP;
            end
            S_RESP: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
